// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions, FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b111;

  // Instruction word: op[15:13] rd[12:10] rs1[9:7] rs2[6:4]; LDI uses imm[9:0]
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 9;
  localparam int IMM_W   = IMM_MSB + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  function automatic logic is_ldi(input logic [2:0] op);
    return op == OP_LDI;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU operand/result bus and retire bus of the
// issue controller, with master (controller) and slave (environment) views.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = alu_pkg::DATA_W_DEF
);
  // Handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both high; the producer holds instr_data stable while
  // instr_valid is high and not yet accepted, and ready never depends on valid.
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr_data;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;

  logic              retire_valid;
  logic [2:0]        retire_rd;
  logic [DATA_W-1:0] retire_data;

  modport master (
    input  instr_valid, instr_data, alu_result,
    output instr_ready, alu_a, alu_b, alu_ctrl,
    output retire_valid, retire_rd, retire_data
  );

  modport slave (
    output instr_valid, instr_data, alu_result,
    input  instr_ready, alu_a, alu_b, alu_ctrl,
    input  retire_valid, retire_rd, retire_data
  );

endinterface

// File: rtl/alu_regfile.sv
// 8-entry register file: three combinational read ports, one synchronous
// write port. Define ALU_ISSUE_ZERO_REG_EN to hardwire r0 to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        rs1_addr,
  input  logic [2:0]        rs2_addr,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [8];
  logic              write_ok;

`ifdef ALU_ISSUE_ZERO_REG_EN
  assign write_ok = (waddr != 3'd0);
  assign rs1_data = (rs1_addr == 3'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 3'd0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];
`else
  assign write_ok = 1'b1;
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dbg_data = regs[dbg_addr];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (we && write_ok) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue front end for the registered ALU: decode, operand read,
// latency wait, write-back and retire. r0 behaviour follows ALU_ISSUE_ZERO_REG_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus,
  output logic              busy,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output state_t            dbg_state
);

  localparam int CNT_W = (ALU_LAT > 2) ? $clog2(ALU_LAT) : 1;

  state_t            state;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [2:0]        alu_ctrl_q;
  logic [2:0]        rd_q;
  logic [DATA_W-1:0] imm_q;
  logic              ldi_q;
  logic              retire_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic [2:0]        op;
  logic              accept;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] wb_data;
  logic              unused_bits;

  assign op          = bus.instr_data[OP_MSB:OP_LSB];
  assign accept      = bus.instr_valid && bus.instr_ready;
  assign unused_bits = ^bus.instr_data[3:0];

  alu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (bus.instr_data[RS1_MSB:RS1_LSB]),
    .rs2_addr (bus.instr_data[RS2_MSB:RS2_LSB]),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data),
    .we       (state == WB),
    .waddr    (rd_q),
    .wdata    (wb_data)
  );

  // The ALU result is only meaningful during WB, so it is sampled there directly.
  assign wb_data = (state != WB) ? '0 : (ldi_q ? imm_q : bus.alu_result);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= OP_ADD;
      rd_q       <= '0;
      imm_q      <= '0;
      ldi_q      <= 1'b0;
      retire_q   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q <= bus.instr_data[RD_MSB:RD_LSB];
            if (is_ldi(op)) begin
              ldi_q    <= 1'b1;
              imm_q    <= DATA_W'(bus.instr_data[IMM_MSB:0]);
              retire_q <= 1'b1;
              state    <= WB;
            end else begin
              ldi_q      <= 1'b0;
              alu_a_q    <= rs1_data;
              alu_b_q    <= rs2_data;
              alu_ctrl_q <= op;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (ALU_LAT > 1) begin
            wait_cnt <= CNT_W'(ALU_LAT - 2);
            state    <= WAIT;
          end else begin
            retire_q <= 1'b1;
            state    <= WB;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            retire_q <= 1'b1;
            state    <= WB;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready  = (state == IDLE) && !rst;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_ctrl     = alu_ctrl_q;
  assign bus.retire_valid = retire_q;
  assign bus.retire_rd    = rd_q;
  assign bus.retire_data  = wb_data;
  assign busy             = (state != IDLE);
  assign dbg_state        = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a one-cycle registered ALU attached; retires
// are checked against a reference register-file model through an expected queue.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ALU_LAT = 1;
  localparam int TMO     = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  state_t            dbg_state;

  int checks = 0;
  int fails = 0;
  int retire_cnt = 0;

  logic [DATA_W+2:0] exp_q[$];
  logic [DATA_W+2:0] mon_exp;
  logic [DATA_W-1:0] model_rf [8];

  alu_issue_ctrl_if #(.DATA_W(DATA_W)) bus ();

  alu_issue_ctrl #(.DATA_W(DATA_W), .ALU_LAT(ALU_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- registered ALU ----------------
  always @(posedge clk) begin
    case (bus.alu_ctrl)
      OP_ADD:  bus.alu_result <= bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result <= bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_result <= bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_result <= bus.alu_a | bus.alu_b;
      OP_NOT:  bus.alu_result <= ~bus.alu_a;
      default: bus.alu_result <= '0;
    endcase
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [DATA_W-1:0] alu_model(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOT:  return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {OP_LDI, rd, imm};
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [2:0] a);
`ifdef ALU_ISSUE_ZERO_REG_EN
    if (a == 3'd0) return '0;
`endif
    return model_rf[a];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.retire_valid) begin
      retire_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL retire_unexpected: got rd=%0d data=%h, required no retire",
                 bus.retire_rd, bus.retire_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.retire_rd, bus.retire_data} !== mon_exp) begin
          fails++;
          $display("FAIL retire: got rd=%0d data=%h, required rd=%0d data=%h",
                   bus.retire_rd, bus.retire_data, mon_exp[DATA_W+2:DATA_W],
                   mon_exp[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents w, waits for ready, records the expected retire and updates the model.
  task automatic issue(input logic [15:0] w, input bit hold);
    int n;
    logic [2:0] op, rd;
    logic [DATA_W-1:0] res;
    op = w[15:13];
    rd = w[12:10];
    n = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
    while (!bus.instr_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout: got instr_ready=0 for %0d cycles, required 1", n);
      bus.instr_valid = 1'b0;
      return;
    end
    if (op == OP_LDI) res = DATA_W'(w[9:0]);
    else res = alu_model(op, model_read(w[9:7]), model_read(w[6:4]));
    exp_q.push_back({rd, res});
    model_rf[rd] = res;
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: got busy=1 for %0d cycles, required 0", n);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== model_read(3'(i))) begin
        fails++;
        $display("FAIL %s_r%0d: got %h, required %h", tag, i, dbg_data, model_read(3'(i)));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    dbg_addr = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_in_rst: got %b, required 0", bus.instr_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, busy, bus.retire_valid, bus.retire_rd, bus.retire_data} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b rv=%b rd=%0d data=%h, required 1 0 0 0 0",
               bus.instr_ready, busy, bus.retire_valid, bus.retire_rd, bus.retire_data);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {32'd0, 32'd0, 3'd0}) begin
      fails++;
      $display("FAIL reset_alu: got a=%h b=%h ctrl=%b, required 0 0 000",
               bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    check_regs("reset");
  endtask

  task automatic test_ldi();
    issue(enc_ldi(3'd1, 10'd10), 1'b0);
    issue(enc_ldi(3'd2, 10'd5), 1'b0);
    wait_idle();
    dbg_addr = 3'd1;
    #1;
    checks++;
    if (dbg_data !== 32'd10) begin
      fails++;
      $display("FAIL ldi_dbg_r1: got %h, required 0000000a", dbg_data);
    end
  endtask

  task automatic test_add_timing();
    wait_idle();
    issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2), 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, busy, bus.instr_ready, bus.retire_valid} !==
        {32'd10, 32'd5, OP_ADD, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL add_issue: got a=%h b=%h ctrl=%b busy=%b ready=%b rv=%b, required a b 000 1 0 0",
               bus.alu_a, bus.alu_b, bus.alu_ctrl, busy, bus.instr_ready, bus.retire_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.retire_valid, bus.retire_rd, bus.retire_data} !== {1'b1, 3'd3, 32'd15}) begin
      fails++;
      $display("FAIL add_retire: got rv=%b rd=%0d data=%h, required 1 3 0000000f",
               bus.retire_valid, bus.retire_rd, bus.retire_data);
    end
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL add_ready_again: got %b, required 1", bus.instr_ready);
    end
  endtask

  task automatic test_alu_ops();
    issue(enc(OP_SUB, 3'd4, 3'd2, 3'd1), 1'b0);
    issue(enc(OP_AND, 3'd5, 3'd1, 3'd2), 1'b0);
    issue(enc(OP_OR,  3'd6, 3'd1, 3'd2), 1'b0);
    issue(enc(OP_NOT, 3'd7, 3'd1, 3'd2), 1'b0);
    wait_idle();
    checks++;
    if ({model_rf[4], model_rf[5], model_rf[6], model_rf[7]} !==
        {32'hFFFF_FFFB, 32'd0, 32'd15, 32'hFFFF_FFF5}) begin
      fails++;
      $display("FAIL ops_model: got %h %h %h %h, required fffffffb 0 f fffffff5",
               model_rf[4], model_rf[5], model_rf[6], model_rf[7]);
    end
    issue(enc_ldi(3'd3, 10'h3FF), 1'b0);
    wait_idle();
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {32'd10, 32'd5, OP_NOT}) begin
      fails++;
      $display("FAIL ldi_holds_alu: got a=%h b=%h ctrl=%b, required 0000000a 00000005 100",
               bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    issue(enc(3'b101, 3'd6, 3'd1, 3'd2), 1'b0);
    issue(enc(OP_ADD, 3'd2, 3'd2, 3'd2), 1'b0);
    wait_idle();
    check_regs("ops");
  endtask

  task automatic test_back_to_back();
    int base;
    logic [2:0] op;
    logic [15:0] w;
    base = retire_cnt;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_AND;
        3: op = OP_OR;
        4: op = OP_NOT;
        default: op = OP_LDI;
      endcase
      if (op == OP_LDI) w = enc_ldi(3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
      else w = enc(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      issue(w, i != 19);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (retire_cnt - base !== 20) begin
      fails++;
      $display("FAIL b2b_count: got %0d retires, required 20", retire_cnt - base);
    end
    check_regs("b2b");
  endtask

  task automatic test_zero_reg();
    issue(enc_ldi(3'd0, 10'd7), 1'b0);
    wait_idle();
    dbg_addr = 3'd0;
    #1;
    checks++;
`ifdef ALU_ISSUE_ZERO_REG_EN
    if (dbg_data !== 32'd0) begin
      fails++;
      $display("FAIL zero_r0: got %h, required 00000000", dbg_data);
    end
`else
    if (dbg_data !== 32'd7) begin
      fails++;
      $display("FAIL zero_r0: got %h, required 00000007", dbg_data);
    end
`endif
    issue(enc(OP_ADD, 3'd1, 3'd0, 3'd0), 1'b0);
    wait_idle();
    check_regs("zero");
  endtask

  task automatic test_rst_mid();
    wait_idle();
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = enc(OP_ADD, 3'd3, 3'd1, 3'd2);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbg_state, bus.instr_ready} !== {ISSUE, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid_state: got state=%0d ready=%b, required 1 0",
               dbg_state, bus.instr_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, busy, bus.retire_valid, bus.alu_a, bus.alu_b} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL rst_mid_outputs: got ready=%b busy=%b rv=%b a=%h b=%h, required 1 0 0 0 0",
               bus.instr_ready, busy, bus.retire_valid, bus.alu_a, bus.alu_b);
    end
    check_regs("rst_mid");
    repeat (4) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ldi();
    test_add_timing();
    test_alu_ops();
    test_back_to_back();
    test_zero_reg();
    test_rst_mid();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drained: got %0d pending retires, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream issue stage for the 32-bit ALU (ops: ADD 000, SUB 001, AND 010, OR 011, NOT 100; 101/110 hit the ALU default case).
- Accepts 16-bit instruction words over a valid/ready handshake.
- Reads operands from an internal 8x32 register file and drives alu_a/alu_b/alu_ctrl.
- Waits for the ALU's registered latency, then writes alu_result back and emits a one-cycle retire pulse.
- Executes one instruction at a time, so there are no hazards.

Parameters:
DATA_W, 32, datapath / register width; must match the ALU.
ALU_LAT, 1, clock cycles from ALU inputs to valid alu_result; legal range is 1 or more.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instr_data is valid
instr_ready  out  1  block can accept an instruction
instr_data  in  16  op[15:13], rd[12:10], rs1[9:7], rs2[6:4], [3:0] ignored; for LDI, imm[9:0]
alu_a  out  DATA_W  ALU operand A (registered)
alu_b  out  DATA_W  ALU operand B (registered)
alu_ctrl  out  3  ALU opcode (registered)
alu_result  in  DATA_W  ALU result
busy  out  1  state is not IDLE
retire_valid  out  1  one-cycle pulse when an instruction completes
retire_rd  out  3  destination register of the retiring instruction
retire_data  out  DATA_W  value written to retire_rd
dbg_addr  in  3  debug register read address
dbg_data  out  DATA_W  combinational read of reg[dbg_addr]

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, WB.
- instr_ready = (state==IDLE) && !rst. An instruction is accepted when instr_valid && instr_ready.
- Reset values:
  - state IDLE; all 8 registers 0.
  - alu_a = 0, alu_b = 0, alu_ctrl = 000.
  - retire_valid = 0, retire_rd = 0, retire_data = 0, busy = 0.
- ALU op (op != 111), accepted in cycle N:
  - At the edge ending cycle N: alu_a <= reg[rs1], alu_b <= reg[rs2], alu_ctrl <= op, rd latched. Next state ISSUE.
  - Cycle N+1 (ISSUE): operands are stable at the ALU.
    - ALU_LAT == 1: next state WB.
    - ALU_LAT > 1: next state WAIT, where a counter holds for ALU_LAT-1 cycles, then WB.
  - WB cycle is N+1+ALU_LAT: retire_valid = 1, retire_rd = rd, retire_data = alu_result. reg[rd] <= alu_result at the end of WB. Next state IDLE.
  - Throughput with ALU_LAT = 1 is one instruction per 3 cycles.
- LDI (op == 111), accepted in cycle N:
  - Not sent to the ALU; alu_a/alu_b/alu_ctrl hold their previous values.
  - Next state WB with retire_data = {zero-extend imm[9:0]} to DATA_W.
  - Retires in cycle N+1, then returns to IDLE.
- alu_a/alu_b/alu_ctrl hold their values after issue until the next ALU op is accepted.
- NOT (100): alu_b is still driven with reg[rs2]; the ALU ignores it.
- Opcodes 101/110 are issued unchanged. Whatever alu_result the ALU returns is written back.
- rs1 == rs2 == rd is legal. Operands are the pre-write values, and the write happens in WB.
- In non-IDLE states, instr_data is ignored and instr_valid may stay high. The stalled instruction is accepted on return to IDLE.
- dbg_data reads the current register contents combinationally; it does not bypass a write happening in the same cycle.
- rst asserted mid-operation (any state): on the next edge the FSM returns to IDLE, the in-flight instruction is dropped, and no regfile write or retire occurs. Registers and outputs take their reset values.

Optional Feature:
ALU_ISSUE_ZERO_REG_EN
- Defined: r0 is hardwired to 0. Reads of r0 (operands and dbg) return 0. Writes to r0 are discarded, but retire_valid still pulses with retire_rd = 0 and retire_data = the computed value.
- Undefined: r0 is an ordinary register.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD 000, OP_SUB 001, OP_AND 010, OP_OR 011, OP_NOT 100, OP_LDI 111
  - instruction field bit positions
  - FSM state typedef {IDLE, ISSUE, WAIT, WB}
  - DATA_W default
- One sub-module, alu_regfile: 8 x DATA_W, reads rs1/rs2/dbg combinationally, one synchronous write port; honours ALU_ISSUE_ZERO_REG_EN.
- Bench instantiates alu_issue_ctrl with the real ALU connected.

Test Plan:
- Reset, then LDI r1,10 and LDI r2,5 → retire pulses (1,10) then (2,5); dbg_addr=1 reads 10.
- ADD r3,r1,r2 accepted in cycle N (ALU_LAT=1) → alu_a=10, alu_b=5, alu_ctrl=000 at N+1; retire (3,15) at N+2; instr_ready high again at N+3.
- SUB r4,r2,r1 → retire_data = 0xFFFFFFFB. AND r5,r1,r2 → 0. OR r6,r1,r2 → 15. NOT r7,r1 → 0xFFFFFFF5.
- instr_valid held high continuously with back-to-back instructions → exactly one acceptance per IDLE cycle; none dropped or duplicated.
- rst pulsed during ISSUE of ADD r3,r1,r2 → no retire pulse; all registers read 0; instr_ready = 1 the cycle after rst falls.
- With ALU_ISSUE_ZERO_REG_EN: LDI r0,7 → retire (0,7) but dbg r0 reads 0; ADD r1,r0,r0 → 0. Without the macro: dbg r0 reads 7.
